ifetch: RTL and testbench

Instruction-fetch stage for the single-cycle MIPS core. Holds the PC, fetches one word per instruction from instruction memory through a req/ack handshake, and presents the instruction (its Op/Funct fields feed the control decoder) until the core signals commit. On commit it computes the next PC from the decoder's 2-bit next-PC code and starts the next fetch.

---
 rtl/ifetch.sv | 95 +++++++++
 tb/tb_ifetch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake,
// and computes the next PC from the decoder's next-PC code on commit.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        commit,
    input  logic [1:0]  npc_op,
    input  logic [31:0] rs_data,
    output logic        fault,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] npc;
    logic [31:0] br_offset;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        npc = pc_plus4;
        case (npc_op)
            2'b00: npc = pc_plus4;
            2'b01: npc = pc_plus4 + br_offset;
            2'b10: npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            2'b11: npc = rs_data;
            default: npc = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RST;
            pc      <= RESET_PC;
            instr   <= 32'd0;
            retired <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == S_REQ && imem_ack)
                instr <= imem_rdata;
            // A faulting commit still counts as retired; pc stays on the faulting instr.
            if (state == S_HOLD && commit) begin
                retired <= retired + 32'd1;
                if (npc[1:0] == 2'b00)
                    pc <= npc;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fault       = 1'b0;
        case (state)
            S_RST: begin
                state_nx = S_REQ;
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_nx = S_HOLD;
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (commit)
                    state_nx = (npc[1:0] == 2'b00) ? S_REQ : S_FAULT;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: state_nx = S_RST;
        endcase
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: sequential fetch, wait states, branches/jumps,
// jr fault, ignored events, reset mid-fetch and retired counter wrap.
module tb_ifetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        commit;
    logic [1:0]  npc_op;
    logic [31:0] rs_data;
    logic        fault;
    logic [31:0] retired;

    int vectors = 0;
    int errors  = 0;

    ifetch dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr),
        .pc(pc), .pc_plus4(pc_plus4),
        .commit(commit), .npc_op(npc_op), .rs_data(rs_data),
        .fault(fault), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // In REQ: hold ack low for 'waits' cycles, then ack with rdata.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] rdata, input int waits);
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, addr);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            step();
        end
        chk("ack_req", {31'd0, imem_req}, 32'd1);
        chk("ack_addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_instr", instr, rdata);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic do_commit(input logic [1:0] op, input logic [31:0] rs);
        commit  = 1'b1;
        npc_op  = op;
        rs_data = rs;
        step();
        commit  = 1'b0;
        npc_op  = 2'b00;
        rs_data = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h0000_3004);
        step();
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        commit = 1'b0; npc_op = 2'b00; rs_data = 32'h0;
        #1;

        // Reset then sequential fetch, 0 wait states
        do_reset();
        fetch(32'h0000_3000, 32'h0000_0000, 0);
        do_commit(2'b00, 32'h0);
        fetch(32'h0000_3004, 32'h0000_0001, 0);
        do_commit(2'b00, 32'h0);
        fetch(32'h0000_3008, 32'h0000_0002, 0);
        do_commit(2'b00, 32'h0);
        chk("seq_addr", imem_addr, 32'h0000_300C);
        chk("seq_req", {31'd0, imem_req}, 32'd1);
        chk("seq_retired", retired, 32'd3);

        // Wait states: 4 low-ack cycles then ack -> req high 5 cycles
        do_reset();
        fetch(32'h0000_3000, 32'h2008_0005, 4);
        chk("ws_pc4", pc_plus4, 32'h0000_3004);

        // Ack during HOLD ignored
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0; imem_rdata = 32'h0;
        chk("ign_ack_instr", instr, 32'h2008_0005);
        chk("ign_ack_valid", {31'd0, instr_valid}, 32'd1);
        chk("ign_ack_pc", pc, 32'h0000_3000);
        do_commit(2'b00, 32'h0);

        // Commit during REQ ignored
        do_commit(2'b11, 32'h0000_5000);
        chk("ign_cm_req", {31'd0, imem_req}, 32'd1);
        chk("ign_cm_pc", pc, 32'h0000_3004);
        chk("ign_cm_retired", retired, 32'd1);

        // Branch back from 3010
        fetch(32'h0000_3004, 32'h0, 0);
        do_commit(2'b00, 32'h0);
        fetch(32'h0000_3008, 32'h0, 1);
        do_commit(2'b00, 32'h0);
        fetch(32'h0000_300C, 32'h0, 0);
        do_commit(2'b00, 32'h0);
        fetch(32'h0000_3010, 32'h1000_FFFE, 0);
        do_commit(2'b01, 32'h0);
        chk("br_addr", imem_addr, 32'h0000_300C);
        chk("br_retired", retired, 32'd5);

        // Jump, jr, then misaligned jr fault
        do_reset();
        fetch(32'h0000_3000, 32'h0800_0C10, 0);
        do_commit(2'b10, 32'h0);
        chk("j_addr", imem_addr, 32'h0000_3040);
        fetch(32'h0000_3040, 32'h0, 0);
        do_commit(2'b11, 32'h0000_4000);
        chk("jr_addr", imem_addr, 32'h0000_4000);
        fetch(32'h0000_4000, 32'h0, 0);
        do_commit(2'b11, 32'h0000_4002);
        chk("flt_fault", {31'd0, fault}, 32'd1);
        chk("flt_retired", retired, 32'd3);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        step();
        chk("flt_sticky", {31'd0, fault}, 32'd1);
        chk("flt_req", {31'd0, imem_req}, 32'd0);
        chk("flt_valid", {31'd0, instr_valid}, 32'd0);
        chk("flt_pc", pc, 32'h0000_4000);
        chk("flt_instr", instr, 32'h0);
        do_reset();

        // Reset during REQ with simultaneous ack; stale ack in RST ignored
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        step();
        rst = 1'b0;
        chk("mid_instr", instr, 32'h0);
        chk("mid_pc", pc, 32'h0000_3000);
        chk("mid_req_rst", {31'd0, imem_req}, 32'd0);
        chk("mid_valid", {31'd0, instr_valid}, 32'd0);
        step();
        imem_ack = 1'b0; imem_rdata = 32'h0;
        chk("stale_instr", instr, 32'h0);
        chk("stale_valid", {31'd0, instr_valid}, 32'd0);
        chk("stale_req", {31'd0, imem_req}, 32'd1);

        // retired wrap
        fetch(32'h0000_3000, 32'h0, 0);
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        do_commit(2'b00, 32'h0);
        chk("wrap_retired", retired, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0000_3004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
